// File: rtl/scoreboard_issue_control.sv
// Issue-stage scoreboard: per-register pending-write countdowns plus a post-jump block window.
// Optional SCOREBOARD_STATS_EN adds a saturating stall_cycles counter.
module scoreboard_issue_control #(
  parameter int NUM_REGS       = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int WB_LATENCY     = 3,
  parameter int JUMP_PENALTY   = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      issue_valid,
  input  logic                      src0_used,
  input  logic [REG_ADDR_WIDTH-1:0] src0_reg,
  input  logic                      src1_used,
  input  logic [REG_ADDR_WIDTH-1:0] src1_reg,
  input  logic                      dst_used,
  input  logic [REG_ADDR_WIDTH-1:0] dst_reg,
  input  logic                      is_jump,
  input  logic                      flush,
  output logic                      stall,
  output logic                      issue_fire,
  output logic [NUM_REGS-1:0]       busy_mask
`ifdef SCOREBOARD_STATS_EN
  ,
  output logic [31:0]               stall_cycles
`endif
);

  localparam int CW = ($clog2(WB_LATENCY + 1) > 0) ? $clog2(WB_LATENCY + 1) : 1;
  localparam int JW = ($clog2(JUMP_PENALTY + 1) > 0) ? $clog2(JUMP_PENALTY + 1) : 1;

  logic [CW-1:0] cnt [NUM_REGS];
  logic [JW-1:0] jcnt;
  logic          src0_busy;
  logic          src1_busy;
  logic          dst_busy;
  logic          hazard;

  always_comb begin
    for (int unsigned r = 0; r < NUM_REGS; r++) begin
      busy_mask[r] = (cnt[r] != '0);
    end
  end

  // Lookup by matching against in-range indices only, so out-of-range addresses read as idle.
  always_comb begin
    src0_busy = 1'b0;
    src1_busy = 1'b0;
    dst_busy  = 1'b0;
    for (int unsigned r = 0; r < NUM_REGS; r++) begin
      if (src0_reg == REG_ADDR_WIDTH'(r)) src0_busy = busy_mask[r];
      if (src1_reg == REG_ADDR_WIDTH'(r)) src1_busy = busy_mask[r];
      if (dst_reg  == REG_ADDR_WIDTH'(r)) dst_busy  = busy_mask[r];
    end
  end

  always_comb begin
    hazard     = (src0_used & src0_busy) | (src1_used & src1_busy) |
                 (dst_used & dst_busy) | (jcnt != '0);
    stall      = issue_valid & (hazard | flush);
    issue_fire = issue_valid & ~hazard & ~flush;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
        cnt[r] <= '0;
      end
    end else begin
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
        if (issue_fire && dst_used && (dst_reg == REG_ADDR_WIDTH'(r))) begin
          cnt[r] <= CW'(WB_LATENCY);
        end else if (cnt[r] != '0) begin
          cnt[r] <= cnt[r] - 1'b1;
        end
      end
    end
  end

  // Flush only cancels the jump window; register writes already issued stay in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      jcnt <= '0;
    end else if (flush) begin
      jcnt <= '0;
    end else if (issue_fire && is_jump) begin
      jcnt <= JW'(JUMP_PENALTY);
    end else if (jcnt != '0) begin
      jcnt <= jcnt - 1'b1;
    end
  end

`ifdef SCOREBOARD_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles <= '0;
    end else if (stall && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule
